// File: rtl/game_ctrl_pkg.sv
// game_ctrl_pkg: FSM state encodings shared by the game controller, renderer and score overlay.
package game_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } state_e;
endpackage

// File: rtl/game_ctrl_btn_debounce.sv
// btn_debounce: two-flop synchroniser, stable-count debounce and rising-edge press detect.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, db_q, db_d, db_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_MAX) db_d = s2_q;
      else cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= i_btn;
      s2_q     <= s1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end
  assign o_level = db_q;
  assign o_press = db_q & ~db_dly_q;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: button conditioning plus IDLE/PLAY/DEAD game FSM feeding the crossyroad renderer.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int DEAD_FRAMES     = 60
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  input  logic       i_collide,
  input  logic       i_frame_tick,
  output logic       o_move,
  output logic       o_game_rst,
  output logic       o_dead,
  output logic [1:0] o_state
);
  localparam int COOL_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam int DEAD_W = $clog2(DEAD_FRAMES + 1);
  state_e state_q, state_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic move_q, move_d, press, level;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_btn  (i_btn),
    .o_level(level),
    .o_press(press)
  );
  // Collision outranks a simultaneous press; a cooldown load outranks the frame decrement.
  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    dead_d  = dead_q;
    move_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cool_d = '0;
        if (press) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (i_collide) begin
          state_d = ST_DEAD;
          dead_d  = DEAD_W'(DEAD_FRAMES);
          cool_d  = '0;
        end else if (press && cool_q == '0) begin
          move_d = 1'b1;
          cool_d = COOL_W'(COOLDOWN_FRAMES);
        end else if (i_frame_tick && cool_q != '0) begin
          cool_d = cool_q - COOL_W'(1);
        end
      end
      ST_DEAD: begin
        if (i_frame_tick) begin
          dead_d  = dead_q - DEAD_W'(1);
          state_d = (dead_q == DEAD_W'(1)) ? ST_IDLE : ST_DEAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cool_q  <= '0;
      dead_q  <= '0;
      move_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      dead_q  <= dead_d;
      move_q  <= move_d;
    end
  end
  assign o_move     = move_q;
  assign o_game_rst = (state_q == ST_IDLE);
  assign o_dead     = (state_q == ST_DEAD);
  assign o_state    = state_q;
endmodule
